inst_rom_loader: RTL and testbench

Instruction memory and boot loader directly upstream of the openmips core's instruction fetch port.
- After reset, receives a program image as a byte stream (valid/ready), assembles big-endian 32-bit words and writes them into internal instruction RAM.
- Verifies an XOR checksum, then releases the core.
- In run, serves the core's rom_ce/rom_addr requests combinationally, so the data is ready in the same cycle the PC is presented.

---
 rtl/inst_rom_loader_if.sv | 19 +
 rtl/inst_rom_loader.sv | 140 ++++++++++++++
 tb/tb_inst_rom_loader.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/inst_rom_loader_if.sv
// Byte-stream load channel and instruction fetch port of the boot loader.
interface inst_rom_loader_if;
  logic [7:0]  rx_data_i;
  logic        rx_valid_i;
  logic        rx_ready_o;
  logic        rom_ce_i;
  logic [31:0] rom_addr_i;
  logic [31:0] rom_data_o;

  modport master (
    output rx_data_i, rx_valid_i, rom_ce_i, rom_addr_i,
    input  rx_ready_o, rom_data_o
  );

  modport slave (
    input  rx_data_i, rx_valid_i, rom_ce_i, rom_addr_i,
    output rx_ready_o, rom_data_o
  );
endinterface

// File: rtl/inst_rom_loader.sv
// Boot loader: receives a checksummed byte image into instruction RAM, then
// releases the core and serves same-cycle instruction fetches.
module inst_rom_loader #(
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  inst_rom_loader_if.slave  bus,
  output logic              cpu_hold_o,
  output logic              load_done_o,
  output logic              load_err_o,
  output logic [ADDR_W:0]   words_loaded_o
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned PTR_W = ADDR_W + 1;

  localparam logic [2:0] S_HDR_HI = 3'd0;
  localparam logic [2:0] S_HDR_LO = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_CSUM   = 3'd3;
  localparam logic [2:0] S_RUN    = 3'd4;
  localparam logic [2:0] S_ERR    = 3'd5;

  logic [2:0]        state_q, state_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [23:0]       buf_q, buf_d;
  logic [1:0]        bidx_q, bidx_d;
  logic [PTR_W-1:0]  wptr_q, wptr_d;
  logic [7:0]        csum_q, csum_d;
  logic              cpu_hold_q, load_done_q, load_err_q;

  logic              accept_c;
  logic              we_c;
  logic [31:0]       wdata_c;
  logic [15:0]       hdr_cnt_c;
  logic [ADDR_W-1:0] ridx_c;
  logic              unused_addr_c;

  logic [31:0] mem [DEPTH];

  // Ready only while loading and never during reset.
  always_comb begin
    bus.rx_ready_o = rst && ((state_q == S_HDR_HI) || (state_q == S_HDR_LO) ||
                             (state_q == S_DATA)   || (state_q == S_CSUM));
  end

  assign accept_c = bus.rx_valid_i & bus.rx_ready_o;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    buf_d     = buf_q;
    bidx_d    = bidx_q;
    wptr_d    = wptr_q;
    csum_d    = csum_q;
    we_c      = 1'b0;
    wdata_c   = {buf_q, bus.rx_data_i};
    hdr_cnt_c = {cnt_q[15:8], bus.rx_data_i};

    if (state_q > S_ERR) begin
      state_d = S_ERR;
    end else if (accept_c) begin
      case (state_q)
        S_HDR_HI: begin
          cnt_d   = {bus.rx_data_i, 8'h00};
          csum_d  = csum_q ^ bus.rx_data_i;
          state_d = S_HDR_LO;
        end
        S_HDR_LO: begin
          cnt_d  = hdr_cnt_c;
          csum_d = csum_q ^ bus.rx_data_i;
          if (32'(hdr_cnt_c) > DEPTH)    state_d = S_ERR;
          else if (hdr_cnt_c == 16'd0)   state_d = S_CSUM;
          else                           state_d = S_DATA;
        end
        S_DATA: begin
          csum_d = csum_q ^ bus.rx_data_i;
          bidx_d = bidx_q + 2'd1;
          buf_d  = {buf_q[15:0], bus.rx_data_i};
          // Fourth byte completes a big-endian word.
          if (bidx_q == 2'd3) begin
            we_c   = 1'b1;
            wptr_d = wptr_q + PTR_W'(1);
            if (32'(wptr_d) == 32'(cnt_q)) state_d = S_CSUM;
          end
        end
        S_CSUM: begin
          state_d = (bus.rx_data_i == csum_q) ? S_RUN : S_ERR;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_HDR_HI;
      cnt_q       <= '0;
      buf_q       <= '0;
      bidx_q      <= '0;
      wptr_q      <= '0;
      csum_q      <= '0;
      cpu_hold_q  <= 1'b1;
      load_done_q <= 1'b0;
      load_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      buf_q       <= buf_d;
      bidx_q      <= bidx_d;
      wptr_q      <= wptr_d;
      csum_q      <= csum_d;
      cpu_hold_q  <= (state_d != S_RUN);
      load_done_q <= (state_d == S_RUN);
      load_err_q  <= (state_d == S_ERR);
    end
  end

  // RAM is deliberately not cleared by reset.
  always_ff @(posedge clk) begin
    if (we_c) mem[wptr_q[ADDR_W-1:0]] <= wdata_c;
  end

  assign cpu_hold_o     = cpu_hold_q;
  assign load_done_o    = load_done_q;
  assign load_err_o     = load_err_q;
  assign words_loaded_o = wptr_q;

  // Same-cycle fetch; words beyond the current image read as zero.
  assign ridx_c        = bus.rom_addr_i[ADDR_W+1:2];
  assign unused_addr_c = ^{bus.rom_addr_i[31:ADDR_W+2], bus.rom_addr_i[1:0]};

  always_comb begin
    bus.rom_data_o = '0;
    if (bus.rom_ce_i && (state_q == S_RUN) && (32'(ridx_c) < 32'(cnt_q)))
      bus.rom_data_o = mem[ridx_c];
  end

endmodule

// File: tb/tb_inst_rom_loader.sv
// Randomized self-checking bench for inst_rom_loader against an image-level model.
module tb_inst_rom_loader;
  localparam int unsigned ADDR_W = 10;
  localparam int unsigned DEPTH  = 1 << ADDR_W;

  typedef logic [7:0] u8_t;

  logic clk = 1'b0;
  logic rst;
  logic cpu_hold, load_done, load_err;
  logic [ADDR_W:0] words_loaded;

  always #5 clk = ~clk;

  inst_rom_loader_if bus();

  inst_rom_loader #(.ADDR_W(ADDR_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .bus            (bus),
    .cpu_hold_o     (cpu_hold),
    .load_done_o    (load_done),
    .load_err_o     (load_err),
    .words_loaded_o (words_loaded)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state for the current image.
  int          m_cnt;
  int          m_acc;
  int          m_words_exp;
  bit          m_done;
  bit          m_err;
  logic [31:0] m_words[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Outcome of an image as a whole: header, words, checksum verdict.
  task automatic model(input u8_t img[$]);
    int  cnt;
    u8_t cs;
    m_words.delete();
    m_done = 0; m_err = 0; m_cnt = 0; m_words_exp = 0;
    cnt = int'(img[0]) * 256 + int'(img[1]);
    if (cnt > int'(DEPTH)) begin
      m_err = 1;
      m_acc = 2;
    end else begin
      cs = 8'h00;
      for (int i = 0; i < 2 + 4 * cnt; i++) cs = cs ^ img[i];
      for (int w = 0; w < cnt; w++)
        m_words.push_back({img[2+4*w], img[3+4*w], img[4+4*w], img[5+4*w]});
      m_cnt       = cnt;
      m_words_exp = cnt;
      m_acc       = 3 + 4 * cnt;
      if (img[m_acc-1] == cs) m_done = 1;
      else                    m_err  = 1;
    end
  endtask

  function automatic logic [31:0] ref_read(input logic [31:0] addr, input logic ce);
    int idx;
    idx = int'((addr >> 2) % DEPTH);
    if (ce && m_done && idx < m_cnt) return m_words[idx];
    return 32'h0;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    bus.rx_valid_i = 1'($urandom_range(0, 1));
    bus.rx_data_i  = 8'($urandom);
    #1 check_eq("rdy_in_reset", 32'(bus.rx_ready_o), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    bus.rx_valid_i = 1'b0;
    @(negedge clk);
    check_eq("rst_words", 32'(words_loaded), 32'h0);
    check_eq("rst_hold",  32'(cpu_hold),     32'h1);
    check_eq("rst_done",  32'(load_done),    32'h0);
    check_eq("rst_err",   32'(load_err),     32'h0);
  endtask

  task automatic push(input u8_t b, input bit exp_acc, input int max_gap);
    int g;
    @(negedge clk);
    bus.rx_valid_i = 1'b1;
    bus.rx_data_i  = b;
    check_eq("rx_ready", 32'(bus.rx_ready_o), 32'(exp_acc));
    @(posedge clk);
    #1;
    bus.rx_valid_i = 1'b0;
    bus.rx_data_i  = 8'($urandom);
    g = (max_gap > 0) ? $urandom_range(0, max_gap) : 0;
    repeat (g) begin
      @(negedge clk);
      bus.rx_data_i = 8'($urandom);
    end
  endtask

  task automatic rd(input logic [31:0] addr, input logic ce, input logic [31:0] exp, input string tag);
    @(negedge clk);
    bus.rom_ce_i   = ce;
    bus.rom_addr_i = addr;
    #1 check_eq(tag, bus.rom_data_o, exp);
  endtask

  task automatic run_image(input u8_t img[$], input int max_gap, input bit with_reset, input int n_rd);
    logic [31:0] a;
    logic        ce;
    int          idx;
    if (with_reset) do_reset();
    model(img);
    for (int i = 0; i < img.size(); i++) push(img[i], i < m_acc, max_gap);
    @(negedge clk);
    check_eq("done",    32'(load_done),    32'(m_done));
    check_eq("err",     32'(load_err),     32'(m_err));
    check_eq("hold",    32'(cpu_hold),     32'(!m_done));
    check_eq("words",   32'(words_loaded), 32'(m_words_exp));
    check_eq("rdy_end", 32'(bus.rx_ready_o), 32'h0);
    for (int k = 0; k < n_rd; k++) begin
      a   = $urandom;
      idx = $urandom_range(0, m_cnt + 2) % int'(DEPTH);
      if (k == 0 && m_cnt > 0) idx = m_cnt - 1;
      if (k == 1) idx = m_cnt % int'(DEPTH);
      a[ADDR_W+1:2] = ADDR_W'(idx);
      ce = ($urandom_range(0, 3) != 0);
      rd(a, ce, ref_read(a, ce), "rd_rand");
    end
  endtask

  function automatic void make_image(input int cnt, input bit bad, output u8_t img[$]);
    u8_t cs;
    img.delete();
    img.push_back(8'(cnt >> 8));
    img.push_back(8'(cnt));
    for (int i = 0; i < 4 * cnt; i++) img.push_back(8'($urandom));
    cs = 8'h00;
    foreach (img[i]) cs = cs ^ img[i];
    if (bad) cs = cs ^ 8'($urandom_range(1, 255));
    img.push_back(cs);
  endfunction

  u8_t img1[$];
  u8_t img[$];

  initial begin
    rst            = 1'b0;
    bus.rx_valid_i = 1'b0;
    bus.rx_data_i  = 8'h00;
    bus.rom_ce_i   = 1'b0;
    bus.rom_addr_i = 32'h0;
    repeat (2) @(posedge clk);

    img1 = '{8'h00, 8'h02, 8'h34, 8'h01, 8'h11, 8'h00, 8'h34, 8'h02, 8'h00, 8'h20, 8'h30};

    // Nominal image with directed reads.
    run_image(img1, 0, 1'b1, 4);
    rd(32'h0000_0000, 1'b1, 32'h3401_1100, "t1_a0");
    rd(32'h0000_0004, 1'b1, 32'h3402_0020, "t1_a4");
    rd(32'h0000_0008, 1'b1, 32'h0,         "t1_a8");
    rd(32'h0000_1002, 1'b1, 32'h3401_1100, "t1_alias");
    rd(32'h0000_0000, 1'b0, 32'h0,         "t1_ce0");

    // Bad checksum.
    img = img1;
    img[10] = 8'h31;
    run_image(img, 0, 1'b1, 2);
    rd(32'h0, 1'b1, 32'h0, "t2_a0");

    // Oversized header, trailing bytes must be refused.
    img = '{8'h04, 8'h01, 8'h12, 8'h34, 8'h56};
    run_image(img, 0, 1'b1, 2);

    // Gapped delivery with junk data between valid bytes.
    run_image(img1, 3, 1'b1, 4);
    rd(32'h0000_0004, 1'b1, 32'h3402_0020, "t4_a4");

    // Reset in the middle of DATA after one word landed.
    do_reset();
    for (int i = 0; i < 6; i++) push(img1[i], 1'b1, 1);
    @(negedge clk);
    check_eq("mid_words", 32'(words_loaded), 32'h1);
    do_reset();
    run_image(img1, 0, 1'b0, 4);
    rd(32'h0, 1'b1, 32'h3401_1100, "t5_a0");

    // Full-depth image, then empty image must hide stale RAM.
    make_image(int'(DEPTH), 1'b0, img);
    run_image(img, 0, 1'b1, 6);
    img = '{8'h00, 8'h00, 8'h00};
    run_image(img, 0, 1'b1, 6);
    rd(32'h0, 1'b1, 32'h0, "t6_a0");

    // Random images, good and bad checksums.
    for (int t = 0; t < 8; t++) begin
      make_image($urandom_range(1, 6), ($urandom_range(0, 1) == 1), img);
      run_image(img, 2, 1'b1, 8);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
